// File: rtl/iterative_shifter.sv
// iterative_shifter: multi-cycle SLL/SRL/SRA/ROL unit shifting STEP bits per clock
module iterative_shifter #(
    parameter int WIDTH   = 34,
    parameter int SHAMT_W = 6,
    parameter int STEP    = 1
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic [1:0]         i_mode,
    input  logic [WIDTH-1:0]   i_data_in,
    input  logic [SHAMT_W-1:0] i_shamt,
    output logic               o_ready,
    output logic               o_busy,
    output logic               o_done,
    output logic [WIDTH-1:0]   o_data_out
);
    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;
    state_t               r_state, w_next;
    logic [WIDTH-1:0]     r_work, r_data_out, w_shifted;
    logic [SHAMT_W-1:0]   r_rem;
    logic [1:0]           r_mode;
    logic [SHAMT_W+3:0]   w_rem_x;
    logic                 w_accept, w_last;
    assign o_ready    = r_state != S_SHIFT;
    assign o_busy     = r_state == S_SHIFT;
    assign o_done     = r_state == S_DONE;
    assign o_data_out = r_data_out;
    assign w_accept   = o_ready & i_start;
    assign w_rem_x    = {4'b0, r_rem};
    assign w_last     = w_rem_x <= (SHAMT_W+4)'(STEP);
    // apply min(STEP, remaining) single-bit shifts to the work register
    always_comb begin
        w_shifted = r_work;
        for (int i = 0; i < STEP; i++)
            if ((SHAMT_W+4)'(i) < w_rem_x)
                w_shifted = r_mode == 2'b00 ? {w_shifted[WIDTH-2:0], 1'b0} :
                            r_mode == 2'b01 ? {1'b0, w_shifted[WIDTH-1:1]} :
                            r_mode == 2'b10 ? {w_shifted[WIDTH-1], w_shifted[WIDTH-1:1]} :
                                              {w_shifted[WIDTH-2:0], w_shifted[WIDTH-1]};
    end
    // next state: accept from IDLE/DONE, leave SHIFT on the final step
    always_comb begin
        w_next = r_state;
        if (r_state == S_SHIFT)
            w_next = w_last ? S_DONE : S_SHIFT;
        else
            w_next = w_accept ? (i_shamt == '0 ? S_DONE : S_SHIFT) : S_IDLE;
    end
    // state, operand capture, iteration and result update
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state    <= S_IDLE;
            r_work     <= '0;
            r_rem      <= '0;
            r_mode     <= '0;
            r_data_out <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_work <= i_data_in;
                r_rem  <= i_shamt;
                r_mode <= i_mode;
                if (i_shamt == '0)
                    r_data_out <= i_data_in;
            end else if (r_state == S_SHIFT) begin
                r_work <= w_shifted;
                r_rem  <= w_last ? '0 : r_rem - SHAMT_W'(STEP);
                if (w_last)
                    r_data_out <= w_shifted;
            end
        end
    end
endmodule

// File: tb/tb_iterative_shifter.sv
// tb_iterative_shifter: directed checks of the iterative shifter at STEP=1 and STEP=4
module tb_iterative_shifter;
    logic        clk = 0, rst = 1, start = 0;
    logic [1:0]  mode = 0;
    logic [33:0] data_in = 0;
    logic [5:0]  shamt = 0;
    logic        rdy1, busy1, done1, rdy4, busy4, done4, sel4 = 0;
    logic [33:0] dout1, dout4;
    int          errors = 0, checks = 0;

    iterative_shifter #(.WIDTH(34), .SHAMT_W(6), .STEP(1)) dut1 (
        .i_clock(clk), .i_reset(rst), .i_start(start), .i_mode(mode),
        .i_data_in(data_in), .i_shamt(shamt), .o_ready(rdy1), .o_busy(busy1),
        .o_done(done1), .o_data_out(dout1));
    iterative_shifter #(.WIDTH(34), .SHAMT_W(6), .STEP(4)) dut4 (
        .i_clock(clk), .i_reset(rst), .i_start(start), .i_mode(mode),
        .i_data_in(data_in), .i_shamt(shamt), .o_ready(rdy4), .o_busy(busy4),
        .o_done(done4), .o_data_out(dout4));

    always #5 clk = ~clk;

    wire        w_rdy  = sel4 ? rdy4  : rdy1;
    wire        w_busy = sel4 ? busy4 : busy1;
    wire        w_done = sel4 ? done4 : done1;
    wire [33:0] w_dout = sel4 ? dout4 : dout1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // called at a negedge: present the request, the next posedge is E0, return at the following negedge
    task automatic issue(input logic [1:0] m, input logic [33:0] d, input logic [5:0] s);
        start = 1; mode = m; data_in = d; shamt = s;
        @(negedge clk);
        start = 0; mode = ~m; data_in = ~d; shamt = 6'h2A;
    endtask

    task automatic wait_done(input string tag, input int lat, input logic [33:0] exp, input int base);
        int c = base;
        while (!w_done && c < 200) begin
            @(negedge clk);
            c++;
        end
        chk({tag, "_lat"}, 64'(c), 64'(lat));
        chk({tag, "_data"}, 64'(w_dout), 64'(exp));
    endtask

    task automatic no_done(input string tag, input int n);
        int pulses = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (w_done) pulses++;
        end
        chk(tag, 64'(pulses), 64'd0);
    endtask

    initial begin
        @(negedge clk); @(negedge clk);
        rst = 0;
        chk("rst_ready", 64'(w_rdy), 64'd1);
        chk("rst_busy", 64'(w_busy), 64'd0);
        chk("rst_done", 64'(w_done), 64'd0);
        chk("rst_dout", 64'(w_dout), 64'd0);

        @(negedge clk);
        issue(2'b00, 34'h0_0000_0001, 6'd1);
        wait_done("sll1", 1, 34'h0_0000_0002, 0);

        @(negedge clk);
        issue(2'b00, 34'h0_0000_0003, 6'd20);
        chk("t1_busy", 64'(w_busy), 64'd1);
        chk("t1_ready", 64'(w_rdy), 64'd0);
        repeat (4) @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        chk("t1_ready", 64'(w_rdy), 64'd1);
        chk("t1_busy", 64'(w_busy), 64'd0);
        chk("t1_dout", 64'(w_dout), 64'd0);
        no_done("t1_nodone", 30);

        issue(2'b10, 34'h2_0000_0000, 6'd33);
        wait_done("sra33", 33, 34'h3_FFFF_FFFF, 0);
        @(negedge clk);
        issue(2'b01, 34'h2_0000_0000, 6'd33);
        chk("srl33_hold", 64'(w_dout), 64'h3_FFFF_FFFF);
        wait_done("srl33", 33, 34'h0_0000_0001, 0);

        @(negedge clk);
        issue(2'b11, 34'h2_0000_0001, 6'd35);
        wait_done("rol35", 35, 34'h0_0000_0003, 0);

        @(negedge clk);
        issue(2'b01, 34'h1_2345_6789, 6'd0);
        wait_done("srl0", 0, 34'h1_2345_6789, 0);
        chk("done_ready", 64'(w_rdy), 64'd1);
        issue(2'b00, 34'h1_2345_6789, 6'd4);
        chk("b2b_busy", 64'(w_busy), 64'd1);
        chk("b2b_hold", 64'(w_dout), 64'h1_2345_6789);
        wait_done("b2b_sll4", 4, 34'h2_3456_7890, 0);
        no_done("b2b_single", 3);

        rst = 1;
        @(negedge clk);
        rst = 0;
        sel4 = 1;
        @(negedge clk);
        issue(2'b00, 34'h0_0000_0001, 6'd10);
        chk("s4_busy", 64'(w_busy), 64'd1);
        start = 1; mode = 2'b01; data_in = 34'h3_FFFF_FFFF; shamt = 6'd1;
        @(negedge clk);
        start = 0;
        wait_done("s4_sll10", 3, 34'h0_0000_0400, 1);
        no_done("s4_nodone", 10);
        chk("s4_final", 64'(w_dout), 64'h0_0000_0400);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
